// File: rtl/nv_nvdla_cmac_in_wt_stage_pkg.sv
// Shared CMAC input-stage parameters and lane helpers.
//  ATOMC     lanes per atom
//  BPE       bits per lane element
//  ATOMK_HF  MAC cells fed by this stage
//  STRIPE_ST / LAYER_END   bit positions inside the 9-bit data pd
package nv_nvdla_cmac_in_wt_stage_pkg;

    localparam int unsigned ATOMC     = 8;
    localparam int unsigned BPE       = 8;
    localparam int unsigned ATOMK_HF  = 4;
    localparam int unsigned ATOM_W    = ATOMC * BPE;
    localparam int unsigned PD_W      = 9;
    localparam int unsigned STRIPE_ST = 0;
    localparam int unsigned LAYER_END = 3;

    // Zero every lane whose mask bit is clear.
    function automatic logic [ATOM_W-1:0] mask_lanes(input logic [ATOM_W-1:0] data,
                                                     input logic [ATOMC-1:0]  mask);
        logic [ATOM_W-1:0] res;
        res = '0;
        for (int k = 0; k < int'(ATOMC); k++) begin
            res[k*BPE +: BPE] = mask[k] ? data[k*BPE +: BPE] : BPE'(0);
        end
        return res;
    endfunction

    // True when exactly one select bit is set.
    function automatic logic is_onehot(input logic [ATOMK_HF-1:0] sel);
        return (sel != '0) && ((sel & (sel - ATOMK_HF'(1))) == '0);
    endfunction

endpackage

// File: rtl/nv_nvdla_cmac_wt_cell.sv
// One MAC cell's weight storage: shadow set written by the weight stream,
// active set presented to the MAC, swapped in on a data stripe start.
//  wr_en/wr_data   write a (pre-masked) weight atom into the shadow set
//  swap_en         stripe start seen; promotes shadow to active if loaded
//  clr_vld         layer end seen; drops actv_vld unless a swap happens now
//  actv/actv_vld   active weights and "holds a swapped-in set" flag
module nv_nvdla_cmac_wt_cell
    import nv_nvdla_cmac_in_wt_stage_pkg::*;
(
    input  logic              nvdla_core_clk,
    input  logic              nvdla_core_rstn,
    input  logic              wr_en,
    input  logic [ATOM_W-1:0] wr_data,
    input  logic              swap_en,
    input  logic              clr_vld,
    output logic [ATOM_W-1:0] actv,
    output logic              actv_vld
);

    logic [ATOM_W-1:0] shadow;
    logic              loaded;
    logic              do_swap_c;

    assign do_swap_c = swap_en & loaded;

    // Shadow capture; a same-cycle swap still reads the old shadow value.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            shadow <= '0;
            loaded <= 1'b0;
        end else begin
            if (wr_en) begin
                shadow <= wr_data;
            end
            if (wr_en) begin
                loaded <= 1'b1;
            end else if (do_swap_c) begin
                loaded <= 1'b0;
            end
        end
    end

    // Active set; a swap outranks the layer-end clear.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            actv     <= '0;
            actv_vld <= 1'b0;
        end else if (do_swap_c) begin
            actv     <= shadow;
            actv_vld <= 1'b1;
        end else if (clr_vld) begin
            actv_vld <= 1'b0;
        end
    end

endmodule

// File: rtl/nv_nvdla_cmac_in_wt_stage.sv
// CMAC input stage: registers the data atom (masked lanes zeroed), routes
// weight atoms into per-cell shadow sets, and swaps them live on stripe start.
// Both paths have one cycle of latency so swapped weights line up with the
// stripe-start data beat.
//  wt_*            weight atom stream, wt_sel one-hot target cell
//  dat_*           data atom stream with pd flags
//  mac_dat_*       registered data atom
//  mac_wt_actv     active weights, cell c at [c*ATOM_W +: ATOM_W]
//  mac_wt_actv_vld per-cell active-set valid
//  wt_sel_err      sticky flag for a weight beat with bad select
module nv_nvdla_cmac_in_wt_stage
    import nv_nvdla_cmac_in_wt_stage_pkg::*;
(
    input  logic                       nvdla_core_clk,
    input  logic                       nvdla_core_rstn,
    input  logic                       wt_pvld,
    input  logic [ATOMC-1:0]           wt_mask,
    input  logic [ATOM_W-1:0]          wt_data,
    input  logic [ATOMK_HF-1:0]        wt_sel,
    input  logic                       dat_pvld,
    input  logic [ATOMC-1:0]           dat_mask,
    input  logic [ATOM_W-1:0]          dat_data,
    input  logic [PD_W-1:0]            dat_pd,
    output logic                       mac_dat_pvld,
    output logic [ATOMC-1:0]           mac_dat_mask,
    output logic [ATOM_W-1:0]          mac_dat_data,
    output logic [PD_W-1:0]            mac_dat_pd,
    output logic [ATOMK_HF*ATOM_W-1:0] mac_wt_actv,
    output logic [ATOMK_HF-1:0]        mac_wt_actv_vld,
    output logic                       wt_sel_err
);

    logic              sel_ok_c;
    logic              swap_c;
    logic              layer_end_c;
    logic [ATOM_W-1:0] wt_masked_c;

    assign sel_ok_c    = is_onehot(wt_sel);
    assign swap_c      = dat_pvld & dat_pd[STRIPE_ST];
    assign layer_end_c = dat_pvld & dat_pd[LAYER_END];
    assign wt_masked_c = mask_lanes(wt_data, wt_mask);

    // Sticky select error, cleared only by reset.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            wt_sel_err <= 1'b0;
        end else if (wt_pvld && !sel_ok_c) begin
            wt_sel_err <= 1'b1;
        end
    end

    // Data pipe: valid every cycle, payload held between beats.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            mac_dat_pvld <= 1'b0;
            mac_dat_mask <= '0;
            mac_dat_data <= '0;
            mac_dat_pd   <= '0;
        end else begin
            mac_dat_pvld <= dat_pvld;
            if (dat_pvld) begin
                mac_dat_mask <= dat_mask;
                mac_dat_data <= mask_lanes(dat_data, dat_mask);
                mac_dat_pd   <= dat_pd;
            end
        end
    end

    // One weight cell per MAC cell; a bad select writes nowhere.
    for (genvar c = 0; c < int'(ATOMK_HF); c++) begin : g_cell
        nv_nvdla_cmac_wt_cell u_cell (
            .nvdla_core_clk  (nvdla_core_clk),
            .nvdla_core_rstn (nvdla_core_rstn),
            .wr_en           (wt_pvld & sel_ok_c & wt_sel[c]),
            .wr_data         (wt_masked_c),
            .swap_en         (swap_c),
            .clr_vld         (layer_end_c),
            .actv            (mac_wt_actv[c*ATOM_W +: ATOM_W]),
            .actv_vld        (mac_wt_actv_vld[c])
        );
    end

endmodule

// File: tb/tb_nv_nvdla_cmac_in_wt_stage.sv
// Directed self-checking bench for the CMAC input weight stage.
module tb_nv_nvdla_cmac_in_wt_stage;

    logic         clk;
    logic         rstn;
    logic         wt_pvld;
    logic [7:0]   wt_mask;
    logic [63:0]  wt_data;
    logic [3:0]   wt_sel;
    logic         dat_pvld;
    logic [7:0]   dat_mask;
    logic [63:0]  dat_data;
    logic [8:0]   dat_pd;
    logic         mac_dat_pvld;
    logic [7:0]   mac_dat_mask;
    logic [63:0]  mac_dat_data;
    logic [8:0]   mac_dat_pd;
    logic [255:0] mac_wt_actv;
    logic [3:0]   mac_wt_actv_vld;
    logic         wt_sel_err;

    int checks;
    int errors;

    nv_nvdla_cmac_in_wt_stage dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .wt_pvld         (wt_pvld),
        .wt_mask         (wt_mask),
        .wt_data         (wt_data),
        .wt_sel          (wt_sel),
        .dat_pvld        (dat_pvld),
        .dat_mask        (dat_mask),
        .dat_data        (dat_data),
        .dat_pd          (dat_pd),
        .mac_dat_pvld    (mac_dat_pvld),
        .mac_dat_mask    (mac_dat_mask),
        .mac_dat_data    (mac_dat_data),
        .mac_dat_pd      (mac_dat_pd),
        .mac_wt_actv     (mac_wt_actv),
        .mac_wt_actv_vld (mac_wt_actv_vld),
        .wt_sel_err      (wt_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wt_pvld  = 1'b0;
        wt_mask  = 8'h00;
        wt_data  = 64'h0;
        wt_sel   = 4'b0000;
        dat_pvld = 1'b0;
        dat_mask = 8'h00;
        dat_data = 64'h0;
        dat_pd   = 9'h000;
    endtask

    task automatic wr_wt(input logic [3:0] sel, input logic [7:0] mask, input logic [63:0] data);
        wt_pvld = 1'b1;
        wt_sel  = sel;
        wt_mask = mask;
        wt_data = data;
    endtask

    task automatic put_dat(input logic [7:0] mask, input logic [63:0] data, input logic [8:0] pd);
        dat_pvld = 1'b1;
        dat_mask = mask;
        dat_data = data;
        dat_pd   = pd;
    endtask

    task automatic test_reset();
        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (10) tick();
        checks++;
        if ({mac_dat_pvld, mac_dat_mask, mac_dat_data, mac_dat_pd} !== 82'h0) begin
            errors++;
            $display("FAIL reset_dat: got pvld=%b mask=%h data=%h pd=%h, want all 0",
                     mac_dat_pvld, mac_dat_mask, mac_dat_data, mac_dat_pd);
        end
        checks++;
        if (mac_wt_actv !== 256'h0 || mac_wt_actv_vld !== 4'b0000) begin
            errors++;
            $display("FAIL reset_wt: got actv=%h vld=%b, want 0", mac_wt_actv, mac_wt_actv_vld);
        end
        checks++;
        if (wt_sel_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b want 0", wt_sel_err);
        end
    endtask

    task automatic test_load_swap();
        wr_wt(4'b0010, 8'h0F, {8{8'hA5}});
        tick();
        idle_inputs();
        checks++;
        if (mac_wt_actv_vld !== 4'b0000 || mac_wt_actv !== 256'h0) begin
            errors++;
            $display("FAIL load_no_early_swap: vld=%b actv=%h, want 0", mac_wt_actv_vld, mac_wt_actv);
        end
        put_dat(8'hFF, 64'h8877665544332211, 9'h001);
        tick();
        idle_inputs();
        checks++;
        if (mac_wt_actv !== {64'h0, 64'h0, 64'h00000000A5A5A5A5, 64'h0}) begin
            errors++;
            $display("FAIL swap_cell1: got %h want cell1=00000000a5a5a5a5", mac_wt_actv);
        end
        checks++;
        if (mac_wt_actv_vld !== 4'b0010) begin
            errors++;
            $display("FAIL swap_vld: got %b want 0010", mac_wt_actv_vld);
        end
        checks++;
        if (mac_dat_pvld !== 1'b1 || mac_dat_data !== 64'h8877665544332211 || mac_dat_pd !== 9'h001
            || mac_dat_mask !== 8'hFF) begin
            errors++;
            $display("FAIL swap_dat: got pvld=%b mask=%h data=%h pd=%h, want 1 ff 8877665544332211 001",
                     mac_dat_pvld, mac_dat_mask, mac_dat_data, mac_dat_pd);
        end
        tick();
        checks++;
        if (mac_dat_pvld !== 1'b0 || mac_dat_data !== 64'h8877665544332211 || mac_dat_pd !== 9'h001) begin
            errors++;
            $display("FAIL dat_hold: got pvld=%b data=%h pd=%h, want 0 8877665544332211 001",
                     mac_dat_pvld, mac_dat_data, mac_dat_pd);
        end
    endtask

    task automatic test_same_cycle();
        wr_wt(4'b0100, 8'hFF, {8{8'h11}});
        tick();
        wr_wt(4'b0100, 8'hFF, {8{8'h22}});
        put_dat(8'hFF, 64'h0, 9'h001);
        tick();
        idle_inputs();
        checks++;
        if (mac_wt_actv !== {64'h0, {8{8'h11}}, 64'h00000000A5A5A5A5, 64'h0}) begin
            errors++;
            $display("FAIL same_cycle_old: got %h want cell2=11.. cell1=00000000a5a5a5a5", mac_wt_actv);
        end
        checks++;
        if (mac_wt_actv_vld !== 4'b0110) begin
            errors++;
            $display("FAIL same_cycle_vld: got %b want 0110", mac_wt_actv_vld);
        end
        put_dat(8'hFF, 64'h0, 9'h001);
        tick();
        idle_inputs();
        checks++;
        if (mac_wt_actv !== {64'h0, {8{8'h22}}, 64'h00000000A5A5A5A5, 64'h0}) begin
            errors++;
            $display("FAIL same_cycle_new: got %h want cell2=22..", mac_wt_actv);
        end
    endtask

    task automatic test_sel_err();
        wr_wt(4'b0001, 8'hFF, {8{8'h44}});
        tick();
        wr_wt(4'b0110, 8'hFF, {8{8'h99}});
        tick();
        idle_inputs();
        checks++;
        if (wt_sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_set: got %b want 1", wt_sel_err);
        end
        put_dat(8'hFF, 64'h0, 9'h001);
        tick();
        idle_inputs();
        checks++;
        if (mac_wt_actv !== {64'h0, {8{8'h22}}, 64'h00000000A5A5A5A5, {8{8'h44}}}) begin
            errors++;
            $display("FAIL sel_err_noshadow: got %h want cell2=22.. cell1=a5 low cell0=44..", mac_wt_actv);
        end
        checks++;
        if (mac_wt_actv_vld !== 4'b0111) begin
            errors++;
            $display("FAIL sel_err_vld: got %b want 0111", mac_wt_actv_vld);
        end
        repeat (3) tick();
        checks++;
        if (wt_sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_err_sticky: got %b want 1", wt_sel_err);
        end
    endtask

    task automatic test_layer_end();
        put_dat(8'h81, {8{8'hFF}}, 9'h008);
        tick();
        idle_inputs();
        checks++;
        if (mac_dat_data !== 64'hFF000000000000FF || mac_dat_mask !== 8'h81 || mac_dat_pd !== 9'h008) begin
            errors++;
            $display("FAIL layer_dat: got data=%h mask=%h pd=%h, want ff000000000000ff 81 008",
                     mac_dat_data, mac_dat_mask, mac_dat_pd);
        end
        checks++;
        if (mac_wt_actv_vld !== 4'b0000) begin
            errors++;
            $display("FAIL layer_clr: got %b want 0000", mac_wt_actv_vld);
        end
        wr_wt(4'b1000, 8'hF0, {8{8'h77}});
        tick();
        idle_inputs();
        put_dat(8'hFF, 64'h0, 9'h009);
        tick();
        idle_inputs();
        checks++;
        if (mac_wt_actv_vld !== 4'b1000
            || mac_wt_actv[255:192] !== 64'h7777777700000000) begin
            errors++;
            $display("FAIL layer_swap_wins: got vld=%b cell3=%h want 1000 7777777700000000",
                     mac_wt_actv_vld, mac_wt_actv[255:192]);
        end
    endtask

    task automatic test_reset_mid();
        wr_wt(4'b0010, 8'hFF, {8{8'h55}});
        put_dat(8'hFF, 64'h1234, 9'h000);
        tick();
        #3 rstn = 1'b0;
        #1;
        checks++;
        if (mac_dat_pvld !== 1'b0 || mac_dat_data !== 64'h0 || mac_wt_actv !== 256'h0
            || mac_wt_actv_vld !== 4'b0000 || wt_sel_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: pvld=%b data=%h actv=%h vld=%b err=%b, want all 0",
                     mac_dat_pvld, mac_dat_data, mac_wt_actv, mac_wt_actv_vld, wt_sel_err);
        end
        idle_inputs();
        tick();
        rstn = 1'b1;
        tick();
        put_dat(8'hFF, 64'h0, 9'h001);
        tick();
        idle_inputs();
        checks++;
        if (mac_wt_actv_vld !== 4'b0000 || mac_wt_actv !== 256'h0 || mac_dat_pvld !== 1'b1) begin
            errors++;
            $display("FAIL swap_after_reset: vld=%b actv=%h pvld=%b, want 0000 0 1",
                     mac_wt_actv_vld, mac_wt_actv, mac_dat_pvld);
        end
        wr_wt(4'b0000, 8'hFF, 64'h0);
        tick();
        idle_inputs();
        checks++;
        if (wt_sel_err !== 1'b1) begin
            errors++;
            $display("FAIL sel_zero_err: got %b want 1", wt_sel_err);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        idle_inputs();
        test_reset();
        test_load_swap();
        test_same_cycle();
        test_sel_err();
        test_layer_end();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
